// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the EX/MEM stage.
// Doubleword RAM plus a two-register MMIO window (cycle counter, scratch).
// A request is latched in IDLE, executed at the last ACCESS edge, and its
// result (rdata/rvalid/err) is presented during the single DONE cycle.
module dmem_responder #(
    parameter int          DEPTH       = 512,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [63:0] MMIO_BASE   = 64'h0000_0000_0001_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        re,
    input  logic        we,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    input  logic [2:0]  func3,
    output logic        busy,
    output logic [63:0] rdata,
    output logic        rvalid,
    output logic        err
);

    localparam int          IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW        = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [63:0] RAM_BYTES = 64'(DEPTH) * 64'd8;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wcnt_q;
    logic [63:0]   addr_q, wdata_q;
    logic [2:0]    func3_q;
    logic          re_q, we_q;
    logic [63:0]   rdata_q;
    logic          rvalid_q, err_q;
    logic [63:0]   cyc_q, scratch_q;

    logic [63:0]   mem [DEPTH];

    // Decode of the latched request
    logic [3:0]    nbytes;
    logic [2:0]    amask;
    logic          misalign, in_ram, in_mmio, fault;
    logic [IW-1:0] idx;
    logic [63:0]   word, shifted, load_val, wsh;
    logic [7:0]    be;
    logic          fire;

    assign nbytes   = 4'd1 << func3_q[1:0];
    assign amask    = 3'(nbytes - 4'd1);
    assign misalign = |(addr_q[2:0] & amask);
    assign in_mmio  = (addr_q >= MMIO_BASE) && (addr_q < MMIO_BASE + 64'd16);
    assign in_ram   = (addr_q < RAM_BYTES) && !in_mmio;
    assign fault    = (re_q & we_q)
                    | (re_q & (func3_q == 3'b111))
                    | misalign
                    | ~(in_ram | in_mmio)
                    | (in_mmio & (func3_q[1:0] != 2'b11));
    assign idx      = addr_q[3+IW-1:3];
    assign word     = in_mmio ? (addr_q[3] ? scratch_q : cyc_q) : mem[idx];
    assign shifted  = word >> {addr_q[2:0], 3'b000};
    assign wsh      = wdata_q << {addr_q[2:0], 3'b000};
    assign be       = 8'((9'd1 << nbytes) - 9'd1) << addr_q[2:0];
    assign fire     = (state_q == ACCESS) && (wcnt_q == '0) && !reset;

    // Size and sign handling of the selected lane
    always_comb begin
        load_val = 64'd0;
        case (func3_q)
            3'b000:  load_val = {{56{shifted[7]}},  shifted[7:0]};
            3'b001:  load_val = {{48{shifted[15]}}, shifted[15:0]};
            3'b010:  load_val = {{32{shifted[31]}}, shifted[31:0]};
            3'b011:  load_val = shifted;
            3'b100:  load_val = {56'd0, shifted[7:0]};
            3'b101:  load_val = {48'd0, shifted[15:0]};
            3'b110:  load_val = {32'd0, shifted[31:0]};
            default: load_val = 64'd0;
        endcase
    end

    // Next-state and stall generation
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        case (state_q)
            IDLE: begin
                busy = re | we;
                if (re | we) state_d = ACCESS;
            end
            ACCESS: begin
                busy = 1'b1;
                if (wcnt_q == '0) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // RAM byte-lane writes; contents survive reset
    always_ff @(posedge clk) begin
        if (fire && we_q && !fault && in_ram) begin
            for (int b = 0; b < 8; b++) begin
                if (be[b]) mem[idx][b*8 +: 8] <= wsh[b*8 +: 8];
            end
        end
    end

    // Control state, request latch, result registers and MMIO registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            func3_q   <= '0;
            re_q      <= 1'b0;
            we_q      <= 1'b0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            cyc_q     <= '0;
            scratch_q <= '0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_q + 64'd1;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (re | we) begin
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        func3_q <= func3;
                        re_q    <= re;
                        we_q    <= we;
                        wcnt_q  <= CW'(WAIT_CYCLES - 1);
                    end
                end
                ACCESS: begin
                    if (wcnt_q != '0) begin
                        wcnt_q <= wcnt_q - 1'b1;
                    end else if (fault) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else if (re_q) begin
                        rdata_q  <= load_val;
                        rvalid_q <= 1'b1;
                    end else if (in_mmio && addr_q[3]) begin
                        // counter at +0 is read-only; stores there are dropped
                        scratch_q <= wdata_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign err    = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: byte-addressed reference model, directed plan
// steps followed by randomized loads/stores.
module tb_dmem_responder;
    localparam int          DEPTH = 512;
    localparam int          WAITC = 1;
    localparam logic [63:0] MB    = 64'h0000_0000_0001_0000;

    logic        clk = 1'b0;
    logic        reset, re, we;
    logic [63:0] addr, wdata;
    logic [2:0]  func3;
    logic        busy, rvalid, err;
    logic [63:0] rdata;

    int errors = 0;
    int checks = 0;
    longint unsigned edge_cnt = 0;
    longint unsigned rst_edge = 0;

    logic [7:0]  mb [DEPTH*8];
    logic [63:0] m_scratch, exp_rdata;

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAITC), .MMIO_BASE(MB)) dut (
        .clk(clk), .reset(reset), .re(re), .we(we), .addr(addr), .wdata(wdata),
        .func3(func3), .busy(busy), .rdata(rdata), .rvalid(rvalid), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit m_fault(bit r, bit w, logic [63:0] a, logic [2:0] f3);
        longint unsigned n = 64'd1 << f3[1:0];
        bit inmm = (a >= MB) && (a < MB + 64'd16);
        if (r && w) return 1'b1;
        if (r && f3 == 3'b111) return 1'b1;
        if (a % n != 0) return 1'b1;
        if (inmm) return n != 8;
        return !(a < 64'(DEPTH) * 8);
    endfunction

    function automatic logic [63:0] m_load(logic [63:0] a, logic [2:0] f3);
        int n = 1 << f3[1:0];
        logic [63:0] v = 64'd0;
        if (a >= MB) return m_scratch;
        for (int i = 0; i < n; i++) v = v | (64'(mb[a + 64'(i)]) << (8 * i));
        if (n < 8 && !f3[2] && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
        return v;
    endfunction

    // One full request: request cycle, ACCESS wait, DONE cycle, following idle cycle
    task automatic access(input bit r, input bit w, input logic [63:0] a, input logic [63:0] wd,
                          input logic [2:0] f3, input string tag,
                          output logic [63:0] got, output longint unsigned at_edge);
        bit f;
        int n;
        @(negedge clk);
        re = r; we = w; addr = a; wdata = wd; func3 = f3;
        f = m_fault(r, w, a, f3);
        n = 1 << f3[1:0];
        #1 chk({tag, ".busy_req"}, 64'(busy), 64'(r | w));
        repeat (WAITC) begin
            @(negedge clk);
            chk({tag, ".busy_acc"}, 64'(busy), 64'd1);
        end
        @(negedge clk);
        got     = rdata;
        at_edge = edge_cnt;
        if (f) exp_rdata = 64'd0;
        else if (r) begin
            // counter value at the access edge = edges since the reset edge, minus one
            if (a == MB) exp_rdata = 64'(edge_cnt - 1 - rst_edge);
            else         exp_rdata = m_load(a, f3);
        end else if (w) begin
            if (a == MB + 64'd8) m_scratch = wd;
            else if (a < MB) for (int i = 0; i < n; i++) mb[a + 64'(i)] = wd[8*i +: 8];
        end
        chk({tag, ".busy_done"}, 64'(busy), 64'd0);
        chk({tag, ".rvalid"}, 64'(rvalid), 64'(r && !f));
        chk({tag, ".err"}, 64'(err), 64'(f));
        chk({tag, ".rdata"}, rdata, exp_rdata);
        re = 1'b0; we = 1'b0;
        @(negedge clk);
        chk({tag, ".rvalid_end"}, 64'(rvalid), 64'd0);
        chk({tag, ".err_end"}, 64'(err), 64'd0);
        chk({tag, ".rdata_hold"}, rdata, exp_rdata);
    endtask

    initial begin
        logic [63:0] got, t1, t2, old80;
        longint unsigned e, e1, e2;
        int sel, rw;
        logic [63:0] a;
        logic [2:0]  f3;

        reset = 1'b1; re = 1'b0; we = 1'b0; addr = '0; wdata = '0; func3 = '0;
        repeat (3) @(negedge clk);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.rvalid", 64'(rvalid), 64'd0);
        chk("rst.err", 64'(err), 64'd0);
        chk("rst.rdata", rdata, 64'd0);
        rst_edge = edge_cnt; reset = 1'b0;
        m_scratch = 64'd0; exp_rdata = 64'd0;

        for (int i = 0; i < 32; i++)
            access(0, 1, 64'(i * 8), {$urandom, $urandom}, 3'b011, "init", got, e);

        access(0, 1, 64'h40, 64'h8877_6655_4433_2211, 3'b011, "sd40", got, e);
        access(1, 0, 64'h40, 64'd0, 3'b011, "ld40", got, e);
        chk("ld40.const", got, 64'h8877_6655_4433_2211);
        access(1, 0, 64'h47, 64'd0, 3'b000, "lb47", got, e);
        chk("lb47.const", got, 64'hFFFF_FFFF_FFFF_FF88);
        access(1, 0, 64'h47, 64'd0, 3'b100, "lbu47", got, e);
        chk("lbu47.const", got, 64'h88);
        access(1, 0, 64'h46, 64'd0, 3'b001, "lh46", got, e);
        chk("lh46.const", got, 64'hFFFF_FFFF_FFFF_8877);
        access(1, 0, 64'h44, 64'd0, 3'b010, "lw44", got, e);
        chk("lw44.const", got, 64'hFFFF_FFFF_8877_6655);
        access(0, 1, 64'h41, 64'hAB, 3'b000, "sb41", got, e);
        access(1, 0, 64'h40, 64'd0, 3'b011, "ld40b", got, e);
        chk("ld40b.const", got, 64'h8877_6655_4433_AB11);
        access(1, 0, 64'h42, 64'd0, 3'b010, "lw42mis", got, e);
        access(0, 1, 64'(DEPTH * 8), 64'h1234, 3'b011, "sd_oob", got, e);
        access(1, 0, 64'h0, 64'd0, 3'b011, "ld0", got, e);

        access(1, 0, MB, 64'd0, 3'b011, "cyc1", t1, e1);
        repeat (7) @(negedge clk);
        access(1, 0, MB, 64'd0, 3'b011, "cyc2", t2, e2);
        chk("cyc.diff", t2 - t1, 64'(e2 - e1));
        access(0, 1, MB, 64'h55, 3'b011, "sd_cyc", got, e);
        access(0, 1, MB + 64'd8, 64'hDEAD_BEEF, 3'b011, "sd_scr", got, e);
        access(1, 0, MB + 64'd8, 64'd0, 3'b011, "ld_scr", got, e);
        chk("ld_scr.const", got, 64'hDEAD_BEEF);
        access(1, 0, MB + 64'd8, 64'd0, 3'b010, "lw_scr", got, e);
        access(1, 1, 64'h10, 64'd0, 3'b011, "rewe", got, e);
        access(1, 0, 64'h10, 64'd0, 3'b111, "f3_111", got, e);

        // reset during ACCESS of a store drops the store
        old80 = m_load(64'h80, 3'b011);
        @(negedge clk);
        we = 1'b1; addr = 64'h80; wdata = ~old80; func3 = 3'b011;
        #1 chk("rstacc.busy_req", 64'(busy), 64'd1);
        @(negedge clk);
        reset = 1'b1; we = 1'b0;
        @(negedge clk);
        chk("rstacc.busy", 64'(busy), 64'd0);
        chk("rstacc.rvalid", 64'(rvalid), 64'd0);
        chk("rstacc.err", 64'(err), 64'd0);
        rst_edge = edge_cnt; reset = 1'b0;
        m_scratch = 64'd0; exp_rdata = 64'd0;
        access(1, 0, 64'h80, 64'd0, 3'b011, "ld80", got, e);
        chk("ld80.old", got, old80);
        access(1, 0, MB + 64'd8, 64'd0, 3'b011, "scr_rst", got, e);

        for (int k = 0; k < 60; k++) begin
            sel = $urandom_range(0, 9);
            rw  = $urandom_range(0, 9);
            f3  = 3'($urandom_range(0, 7));
            if (sel <= 6)      a = 64'($urandom_range(0, 255));
            else if (sel == 7) a = MB + 64'($urandom_range(0, 15));
            else if (sel == 8) a = 64'(DEPTH * 8) + 64'($urandom_range(0, 255));
            else begin a = MB + 64'(8 * $urandom_range(0, 1)); f3 = 3'b011; end
            if (sel <= 6 && a > 64'd248) f3 = 3'b000;
            access(rw <= 5, rw == 0 || rw > 5, a, {$urandom, $urandom}, f3, "rand", got, e);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle responder for the core's data-memory port. Services loads and stores issued from the EX/MEM stage.
- Holds a doubleword-organised RAM plus a small MMIO window (free-running cycle counter, scratch register).
- Drives a stall (busy) back to the hazard unit until the access completes.
- Returns sized, sign/zero-extended load data in RV64 func3 encoding.

Parameters:
- DEPTH, 512, number of 64-bit RAM words. RAM spans byte addresses 0 .. DEPTH*8-1.
- WAIT_CYCLES, 1, extra ACCESS-state cycles before completion (≥1).
- MMIO_BASE, 64'h0000_0000_0001_0000, base of MMIO window. +0x0 = cycle counter (RO), +0x8 = scratch (RW).

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- re  in  1  load request; held stable by core while busy=1.
- we  in  1  store request; held stable by core while busy=1.
- addr  in  64  byte address.
- wdata  in  64  store data, right-aligned.
- func3  in  3  access size/sign: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu; stores use func3[1:0].
- busy  out  1  stall request to hazard unit.
- rdata  out  64  load result, registered.
- rvalid  out  1  one-cycle pulse: load data valid.
- err  out  1  one-cycle pulse: access faulted.

Behaviour:
- Reset: state=IDLE, busy=0, rdata=0, rvalid=0, err=0, wait counter=0, cycle counter=0, scratch=0. RAM contents are not cleared.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - busy = re|we, combinational, so the stall is seen in the request cycle.
  - If re|we, latch addr/wdata/func3/re/we, load wait counter with WAIT_CYCLES-1, and go to ACCESS.
- ACCESS:
  - busy=1.
  - Counter>0: decrement and stay.
  - Counter==0: perform the access at this edge (RAM write or read capture into rdata), then go to DONE.
- DONE:
  - busy=0; rvalid=1 if the latched op was a load and no fault; err=1 on fault.
  - Go to IDLE unconditionally. The core advances EX/MEM at this edge, so a new request is taken only in IDLE.
- Latency with WAIT_CYCLES=1: busy high 2 cycles (request cycle + ACCESS); rdata/rvalid are valid in the third cycle and hold rdata until the next load completes.
- Loads:
  - Byte lane is selected by addr[2:0].
  - b/h/w sign-extend to 64 bits; bu/hu/wu zero-extend; d is passed through.
  - func3=111 is a fault.
- Stores: write only the addressed bytes (byte-enable from size and addr[2:0]); other bytes in the word are unchanged.
- Faults (err=1, no RAM/MMIO write, rdata forced 0, rvalid=0):
  - Misaligned: addr not a multiple of access size.
  - Address ≥ DEPTH*8 and outside the MMIO window.
  - MMIO access not doubleword-sized.
  - re and we both high.
  - Load with func3=111.
- MMIO:
  - Cycle counter increments every cycle after reset and wraps at 2^64. Load returns its value at the access edge; stores are ignored without fault.
  - Scratch is fully RW with sd/ld.
- RAM index = addr[3+log2(DEPTH)-1:3].
- Reset asserted in any state returns to IDLE the next edge: busy=0, in-flight store is dropped, no rvalid/err pulse.
- Requests that arrive while not in IDLE are ignored; the core holds them stable per protocol.

Test Plan:
- sd 64'h8877_6655_4433_2211 @0x40, then ld @0x40 → busy high 2 cycles each; rvalid pulses one cycle later with rdata=64'h8877_6655_4433_2211.
- After above: lb @0x47 → rdata=64'hFFFF_FFFF_FFFF_FF88; lbu @0x47 → 64'h88; lh @0x46 → 64'hFFFF_FFFF_FFFF_8877; lw @0x44 → 64'hFFFF_FFFF_8877_6655.
- sb 8'hAB @0x41, then ld @0x40 → 64'h8877_6655_4433_AB11 (other bytes intact).
- lw @0x42 (misaligned) → err pulse, rvalid=0, rdata=0. sd @DEPTH*8 → err, and a later read of RAM word 0 is unchanged.
- ld MMIO_BASE twice, N cycles apart → second minus first = N. sd 64'hDEAD_BEEF @MMIO_BASE+8, then ld → 64'hDEAD_BEEF. lw @MMIO_BASE+8 → err.
- Assert reset during ACCESS of sd @0x80 → next cycle busy=0, no err/rvalid pulse, and a subsequent ld @0x80 returns the old value.
